// File: rtl/lfsr_ctrl_pkg.sv
// lfsr_ctrl_pkg: shared state encoding and LFSR step function for the burst controller
package lfsr_ctrl_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int LFSR_W = 8;
  localparam logic [LFSR_W-1:0] LFSR_TAP_MASK = 8'hB8;
  function automatic logic [LFSR_W-1:0] lfsr8_next(input logic [LFSR_W-1:0] s);
    return {s[6:0], ^(s & LFSR_TAP_MASK)};
  endfunction
endpackage

// File: rtl/lfsr8_load_step.sv
// lfsr8_load_step: 8-bit Fibonacci LFSR register with load (priority) and single-step
module lfsr8_load_step
  import lfsr_ctrl_pkg::*;
#(
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = 8'h01
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LFSR_W-1:0] load_val,
  input  logic              step,
  output logic [LFSR_W-1:0] state
);
  // load wins over step so a fresh seed is never advanced in its load cycle
  always_ff @(posedge clk)
    if (rst) state <= DEFAULT_SEED;
    else if (load) state <= load_val;
    else if (step) state <= lfsr8_next(state);
endmodule

// File: rtl/lfsr_burst_ctrl.sv
// lfsr_burst_ctrl: seeded LFSR burst sequencer; define LFSR_BURST_CTRL_BEAT_CNT_EN for a beat_cnt output
module lfsr_burst_ctrl
  import lfsr_ctrl_pkg::*;
#(
  parameter int                LEN_W        = 8,
  parameter logic [LFSR_W-1:0] DEFAULT_SEED = 8'h01
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [LFSR_W-1:0] req_seed,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LFSR_W-1:0] out_data,
  output logic              out_last,
  output logic              done,
  output logic              busy
`ifdef LFSR_BURST_CTRL_BEAT_CNT_EN
  ,
  output logic [15:0]       beat_cnt
`endif
);
  state_t state;
  logic [LEN_W-1:0] remaining;
  logic accept, fire;
  assign req_ready = state == IDLE;
  assign busy      = state != IDLE;
  assign done      = state == DONE;
  assign out_valid = state == RUN && !abort;
  assign out_last  = state == RUN && remaining == LEN_W'(1);
  assign accept    = req_valid && req_ready;
  assign fire      = out_valid && out_ready;
  lfsr8_load_step #(.DEFAULT_SEED(DEFAULT_SEED)) u_lfsr (
    .clk      (CLK),
    .rst      (RESET),
    .load     (accept),
    .load_val (req_seed == '0 ? DEFAULT_SEED : req_seed),
    .step     (fire),
    .state    (out_data)
  );
  // burst sequencing; leaving RUN at remaining==1 keeps the counter from wrapping
  always_ff @(posedge CLK)
    if (RESET) begin
      state     <= IDLE;
      remaining <= '0;
    end else if (state == IDLE) begin
      if (req_valid) begin
        remaining <= req_len;
        state     <= req_len != '0 ? RUN : DONE;
      end
    end else if (state == RUN) begin
      if (abort) state <= DONE;
      else if (out_ready) begin
        remaining <= remaining - 1'b1;
        if (out_last) state <= DONE;
      end
    end else state <= IDLE;
`ifdef LFSR_BURST_CTRL_BEAT_CNT_EN
  // free-running count of transferred beats, wraps naturally
  always_ff @(posedge CLK)
    if (RESET) beat_cnt <= '0;
    else if (fire) beat_cnt <= beat_cnt + 16'd1;
`endif
endmodule

// File: tb/tb_lfsr_burst_ctrl.sv
// tb_lfsr_burst_ctrl: directed self-checking bench for lfsr_burst_ctrl
module tb_lfsr_burst_ctrl;
  logic       CLK, RESET, req_valid, req_ready, abort, out_valid, out_ready, out_last, done, busy;
  logic [7:0] req_seed, req_len, out_data;
`ifdef LFSR_BURST_CTRL_BEAT_CNT_EN
  logic [15:0] beat_cnt;
`endif
  int errors = 0;
  int checks = 0;

  lfsr_burst_ctrl dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_seed  (req_seed),
    .req_len   (req_len),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .done      (done),
    .busy      (busy)
`ifdef LFSR_BURST_CTRL_BEAT_CNT_EN
    ,
    .beat_cnt  (beat_cnt)
`endif
  );

  initial CLK = 0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic issue(input logic [7:0] seed, input logic [7:0] len);
    req_valid = 1;
    req_seed  = seed;
    req_len   = len;
    tick();
    req_valid = 0;
  endtask

  task automatic test_reset();
    RESET = 1;
    tick();
    tick();
    RESET = 0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b want 1", req_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
`ifdef LFSR_BURST_CTRL_BEAT_CNT_EN
    checks++; if (beat_cnt !== 16'd0) begin errors++; $display("FAIL reset_beat_cnt got %0d want 0", beat_cnt); end
`endif
    out_ready = 0;
    issue(8'h01, 8'd5);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrun_pre_valid got %b want 1", out_valid); end
    RESET = 1;
    tick();
    RESET = 0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL midrun_req_ready got %b want 1", req_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrun_out_valid got %b want 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrun_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrun_done got %b want 0", done); end
    tick();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midrun_discard got valid=%b busy=%b want 0 0", out_valid, busy); end
  endtask

  task automatic test_basic();
    logic [7:0] exp [5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};
    out_ready = 1;
    issue(8'h01, 8'd5);
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid[%0d] got %b want 1", i, out_valid); end
      checks++; if (out_data !== exp[i]) begin errors++; $display("FAIL basic_data[%0d] got %h want %h", i, out_data, exp[i]); end
      checks++; if (out_last !== (i == 4)) begin errors++; $display("FAIL basic_last[%0d] got %b want %b", i, out_last, i == 4); end
      tick();
    end
    checks++; if (done !== 1'b1 || out_valid !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL basic_done got done=%b valid=%b ready=%b want 1 0 0", done, out_valid, req_ready); end
    tick();
    checks++; if (done !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL basic_idle got done=%b ready=%b busy=%b want 0 1 0", done, req_ready, busy); end
  endtask

  task automatic test_zero_seed();
    out_ready = 1;
    issue(8'h00, 8'd2);
    checks++; if (out_data !== 8'h01 || out_valid !== 1'b1) begin errors++; $display("FAIL zseed_beat0 got %h/%b want 01/1", out_data, out_valid); end
    tick();
    checks++; if (out_data !== 8'h02 || out_last !== 1'b1) begin errors++; $display("FAIL zseed_beat1 got %h/%b want 02/1", out_data, out_last); end
    tick();
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL zseed_done got %b want 1", done); end
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1;
    issue(8'h01, 8'd3);
    checks++; if (out_data !== 8'h01) begin errors++; $display("FAIL bp_beat0 got %h want 01", out_data); end
    tick();
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 8'h02 || out_last !== 1'b0) begin errors++; $display("FAIL bp_hold[%0d] got %b/%h/%b want 1/02/0", i, out_valid, out_data, out_last); end
      tick();
    end
    out_ready = 1;
    checks++; if (out_data !== 8'h02) begin errors++; $display("FAIL bp_release got %h want 02", out_data); end
    tick();
    checks++; if (out_data !== 8'h04 || out_last !== 1'b1) begin errors++; $display("FAIL bp_beat2 got %h/%b want 04/1", out_data, out_last); end
    tick();
    checks++; if (done !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_done got %b/%b want 1/0", done, out_valid); end
    tick();
  endtask

  task automatic test_empty();
    out_ready = 1;
    issue(8'h5A, 8'd0);
    checks++; if (out_valid !== 1'b0 || done !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL empty_done got valid=%b done=%b busy=%b want 0 1 1", out_valid, done, busy); end
    tick();
    checks++; if (done !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL empty_idle got done=%b busy=%b ready=%b want 0 0 1", done, busy, req_ready); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1;
    issue(8'h08, 8'd2);
    checks++; if (out_data !== 8'h08) begin errors++; $display("FAIL b2b_a0 got %h want 08", out_data); end
    tick();
    checks++; if (out_data !== 8'h11 || out_last !== 1'b1) begin errors++; $display("FAIL b2b_a1 got %h/%b want 11/1", out_data, out_last); end
    tick();
    tick();
    issue(8'h11, 8'd2);
    checks++; if (out_data !== 8'h11) begin errors++; $display("FAIL b2b_b0 got %h want 11", out_data); end
    tick();
    checks++; if (out_data !== 8'h23) begin errors++; $display("FAIL b2b_b1 got %h want 23", out_data); end
    tick();
    tick();
  endtask

  task automatic test_abort();
    RESET = 1;
    tick();
    RESET = 0;
    out_ready = 1;
    issue(8'h01, 8'd10);
    checks++; if (out_data !== 8'h01) begin errors++; $display("FAIL abort_beat0 got %h want 01", out_data); end
    tick();
    checks++; if (out_data !== 8'h02) begin errors++; $display("FAIL abort_beat1 got %h want 02", out_data); end
    tick();
    abort = 1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b want 0", out_valid); end
    tick();
    abort = 0;
    checks++; if (done !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL abort_done got %b/%b want 1/0", done, out_valid); end
    tick();
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL abort_after got %b/%b want 0/0", out_valid, busy); end
`ifdef LFSR_BURST_CTRL_BEAT_CNT_EN
    checks++; if (beat_cnt !== 16'd2) begin errors++; $display("FAIL abort_beat_cnt got %0d want 2", beat_cnt); end
`endif
  endtask

  initial begin
    RESET = 1; req_valid = 0; req_seed = 0; req_len = 0; abort = 0; out_ready = 0;
    test_reset();
    test_basic();
    test_zero_seed();
    test_backpressure();
    test_empty();
    test_back_to_back();
    test_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lfsr_burst_ctrl.md
Name: lfsr_burst_ctrl

Overview:
Sequencer for the 8-bit Fibonacci LFSR: taps 8,6,5,4; shift toward MSB; feedback = s[7]^s[5]^s[4]^s[3] into bit 0.
- Accepts a burst request (seed, length) over a valid/ready handshake.
- Loads the seed, then streams one LFSR state per accepted output beat.
- Pulses done when the burst ends.
- Sits between test-pattern/scrambler clients and the output stream; owns the LFSR register, start/stop sequencing and seed sanitising.

Parameters:
LEN_W, 8, width of burst length field and remaining-beat counter.
DEFAULT_SEED, 8'h01, substituted when a zero seed is requested (zero is the LFSR lock-up state).

Ports:
CLK  input  1  single clock, rising edge.
RESET  input  1  synchronous, active-high reset.
req_valid  input  1  burst request valid.
req_ready  output  1  controller can accept a request.
req_seed  input  8  initial LFSR state.
req_len  input  LEN_W  number of beats; 0 = empty burst.
abort  input  1  terminate active burst.
out_valid  output  1  out_data valid.
out_ready  input  1  consumer accepts beat.
out_data  output  8  current LFSR state.
out_last  output  1  final beat of burst.
done  output  1  one-cycle pulse at burst end.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Interface: one clock (CLK); reset is synchronous and active-high (RESET).
- States: IDLE, RUN, DONE.
- RESET (any cycle, including mid-burst):
  - state=IDLE, lfsr=DEFAULT_SEED, remaining=0.
  - req_ready=1; out_valid=0, out_last=0, done=0, busy=0.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: lfsr <= (req_seed==0 ? DEFAULT_SEED : req_seed); remaining <= req_len.
  - Next state: RUN if req_len!=0, else DONE.
  - req_valid while not in IDLE is ignored (req_ready=0).
- RUN:
  - out_valid = !abort; out_data = lfsr; out_last = (remaining==1).
  - Latency: first beat valid the cycle after request acceptance.
  - Beat transfers on out_valid&&out_ready. Then lfsr <= {lfsr[6:0], fb}; remaining <= remaining-1; if out_last, go to DONE.
  - While out_valid&&!out_ready: out_data and out_last hold stable; lfsr and remaining do not change.
  - abort high in RUN: no beat transfers that cycle, even if out_ready=1. Next state DONE; lfsr keeps its value.
- DONE: done=1 for exactly one cycle; out_valid=0; next state IDLE.
- Back-to-back bursts:
  - New request acceptable the cycle after DONE.
  - Minimum burst turnaround = len+2 cycles with out_ready tied high.
- Arithmetic:
  - remaining is an LEN_W-bit unsigned down-counter and never wraps; the RUN exit at 1 guarantees this.
  - Maximum burst = 2^LEN_W-1.
- The LFSR never reaches 0, because seed 0 is replaced; maximal period 255.

Optional Feature:
LFSR_BURST_CTRL_BEAT_CNT_EN
- Defined:
  - Adds output port beat_cnt [15:0] counting transferred beats since RESET.
  - Increments on out_valid&&out_ready; wraps 16'hFFFF->0.
  - Reset value 0; unaffected by abort.
- Undefined: port and counter absent; no other behaviour changes.

Decomposition:
Package lfsr_ctrl_pkg:
- state enum {IDLE, RUN, DONE}.
- LFSR_TAP_MASK = 8'hB8 (bits 7,5,4,3).
- LFSR_W = 8.
- Function lfsr8_next(s) returning {s[6:0], ^(s & LFSR_TAP_MASK)}.

Sub-module lfsr8_load_step:
- Holds the 8-bit register, with inputs load, load_val, step, out state.
- Reset value is DEFAULT_SEED.
- load has priority over step.

The controller FSM, counter and handshake stay in lfsr_burst_ctrl.

Test Plan:
1. Assert RESET 2 cycles, then release -> req_ready=1, out_valid=0, done=0, busy=0; RESET mid-RUN -> same values the next cycle, and the burst is discarded.
2. seed=8'h01, len=5, out_ready=1 -> out_data 01,02,04,08,11 on consecutive cycles; out_last only with 11; done pulses one cycle later; req_ready returns the next cycle.
3. seed=8'h00, len=2 -> beats 01,02 (seed replaced).
4. seed=8'h01, len=3, out_ready low for 3 cycles while beat 02 is presented -> 02 held stable with out_valid=1; beat 04 follows when ready rises; 3 beats total.
5. len=0 -> no out_valid; done pulses exactly 1 cycle after acceptance; busy high for that one cycle.
6. seed=8'h01, len=10, abort asserted with out_ready=1 after beats 01,02 -> out_valid=0 in the abort cycle; done next cycle; no further beats; with LFSR_BURST_CTRL_BEAT_CNT_EN, beat_cnt=2.
